fifo_word_serializer: RTL and testbench
=======================================

Name: fifo_word_serializer

Overview:
- Read-side drain stage placed directly downstream of the 32-bit, 8-deep FIFO buffer.
- Pops one word at a time through the FIFO's RD / EMPTY / dataOut interface.
- Splits each word into bytes and presents them on a valid/ready byte stream toward a narrow consumer (UART TX, byte bus).
- Absorbs the FIFO's one-cycle registered read latency and applies backpressure, so no words are lost or duplicated.

Parameters:
- DATA_W, 32, FIFO word width; must be a multiple of BYTE_W.
- BYTE_W, 8, output byte width.
- MSB_FIRST, 1, 1 = most significant byte sent first; 0 = least significant byte first.
- CNT_W, 16, width of the words-completed counter.

Ports:
- CLK  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- EN  in  1  enable; gates the start of new FIFO reads only.
- fifo_empty  in  1  EMPTY flag from the FIFO.
- fifo_data  in  DATA_W  dataOut from the FIFO; valid the cycle after the RD pulse is sampled.
- fifo_rd  out  1  registered single-cycle read strobe to the FIFO RD input.
- byte_out  out  BYTE_W  current output byte.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  consumer accepts byte_out.
- byte_last  out  1  qualifies the final byte of the current word.
- busy  out  1  high in every state except IDLE.
- word_cnt  out  CNT_W  number of words fully transmitted; wraps modulo 2^CNT_W.

Behaviour:
- Reset is synchronous on rst, active-high, clock CLK. On reset:
  - state returns to IDLE.
  - fifo_rd, byte_valid, byte_last, busy clear to 0.
  - byte_out, shift register, byte index and word_cnt clear to 0.
- Reset mid-word discards the partial word. The popped FIFO word is lost; this is accepted.
- The FSM has four states:
  - IDLE: if EN=1 and fifo_empty=0, set fifo_rd<=1 and go to RD. Otherwise stay.
  - RD: fifo_rd<=0 and go to WAIT. The FIFO samples RD=1 at the end of this cycle.
  - WAIT: fifo_data is valid. Capture it into the shift register, set idx<=0 and byte_valid<=1, and go to SEND.
  - SEND: byte_out is the selected byte. On a handshake (byte_valid & byte_ready):
    - if idx < DATA_W/BYTE_W-1, increment idx.
    - otherwise, set byte_valid<=0, increment word_cnt and go to IDLE.
- fifo_rd is exactly one cycle wide per word. It is never asserted outside IDLE->RD, so it never reads while EMPTY was sampled as 1.
- Byte select with MSB_FIRST=1: the byte at idx is bits [DATA_W-1-idx*BYTE_W -: BYTE_W]. With MSB_FIRST=0 it is bits [idx*BYTE_W +: BYTE_W].
- byte_last = byte_valid & (idx == DATA_W/BYTE_W-1).
- Latency: fifo_empty falling at cycle 0 (sampled in IDLE with EN=1) gives fifo_rd=1 in cycle 1 and the first byte_valid=1 in cycle 3.
- Minimum word period with byte_ready held at 1 is 3 + DATA_W/BYTE_W cycles (7 cycles at the defaults).
- Backpressure: while byte_valid=1 and byte_ready=0, byte_out, byte_last and idx hold stable. No timeout applies.
- byte_valid never drops without a handshake, except on rst.
- EN=0 only blocks the IDLE->RD transition. A word already in progress always completes, and EN toggling mid-word has no effect.
- fifo_empty is ignored outside IDLE.
- The shift register is loaded only in WAIT, so fifo_data changes during SEND have no effect.
- word_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset, then FIFO holds 0xA1B2C3D4, EN=1, byte_ready=1 -> fifo_rd pulses 1 cycle; bytes A1, B2, C3, D4 on consecutive cycles starting 3 cycles after the read; byte_last only on D4; word_cnt=1; busy low after.
- Two words 0x01020304 and 0x05060708 back to back, byte_ready=1 -> exactly 2 fifo_rd pulses 7 cycles apart; byte sequence 01..08; word_cnt=2.
- byte_ready=0 for 5 cycles while B2 is presented -> B2 held stable 5 cycles, no extra fifo_rd; stream continues C3, D4 after ready returns.
- fifo_empty=1 throughout, EN=1 -> fifo_rd never asserts, busy=0. Then EN=0 with a word available -> no read. Set EN=1 -> read occurs; EN dropped mid-word -> word still completes.
- MSB_FIRST=0, word 0xA1B2C3D4 -> bytes D4, C3, B2, A1.
- rst asserted while sending the second byte -> next cycle all outputs are 0 and state is IDLE. After rst releases with the FIFO non-empty, a fresh read starts with its first byte at idx 0.

Source files
------------

// File: rtl/fifo_word_serializer.sv
// Drains 32-bit words from a registered-read FIFO and emits them as a valid/ready byte
// stream. Handles the FIFO's one-cycle read latency and holds the byte under backpressure.
module fifo_word_serializer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BYTE_W    = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              EN,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int unsigned NumBytes = DATA_W / BYTE_W;
    localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWait,
        StSend
    } state_e;

    state_e             state_q, state_d;
    logic               fifo_rd_q, fifo_rd_d;
    logic               valid_q, valid_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // State and datapath registers, synchronously cleared.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= StIdle;
            fifo_rd_q <= 1'b0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            fifo_rd_q <= fifo_rd_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic: pop one word, wait out the read latency, then shift out its bytes.
    always_comb begin
        state_d   = state_q;
        fifo_rd_d = 1'b0;
        valid_d   = valid_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        case (state_q)
            StIdle: begin
                if (EN && !fifo_empty) begin
                    fifo_rd_d = 1'b1;
                    state_d   = StRd;
                end
            end
            StRd: begin
                // FIFO samples the strobe at the end of this cycle.
                state_d = StWait;
            end
            StWait: begin
                shift_d = fifo_data;
                idx_d   = '0;
                valid_d = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (valid_q && byte_ready) begin
                    if (idx_q != LastIdx) begin
                        idx_d   = idx_q + 1'b1;
                        // Shift so the next byte always sits in the output slot.
                        shift_d = MSB_FIRST ? (shift_q << BYTE_W) : (shift_q >> BYTE_W);
                    end else begin
                        valid_d = 1'b0;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output byte comes from the fixed end of the shift register.
    always_comb begin
        byte_out = MSB_FIRST ? shift_q[DATA_W-1 -: BYTE_W] : shift_q[BYTE_W-1:0];
    end

    assign fifo_rd    = fifo_rd_q;
    assign byte_valid = valid_q;
    assign byte_last  = valid_q && (idx_q == LastIdx);
    assign busy       = (state_q != StIdle);
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench: FIFO model feeding an MSB-first and an LSB-first (narrow counter) instance.
module tb_fifo_word_serializer;

    logic        CLK;
    logic        rst;
    logic        EN;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        byte_ready;

    logic        fifo_rd, byte_valid, byte_last, busy;
    logic [7:0]  byte_out;
    logic [15:0] word_cnt;

    logic        fifo_rd_l, byte_valid_l, byte_last_l, busy_l;
    logic [7:0]  byte_out_l;
    logic [1:0]  word_cnt_l;

    fifo_word_serializer #(
        .DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b1), .CNT_W(16)
    ) dut (
        .CLK(CLK), .rst(rst), .EN(EN), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .byte_last(byte_last), .busy(busy), .word_cnt(word_cnt)
    );

    fifo_word_serializer #(
        .DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b0), .CNT_W(2)
    ) dut_lsb (
        .CLK(CLK), .rst(rst), .EN(EN), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd_l), .byte_out(byte_out_l), .byte_valid(byte_valid_l),
        .byte_ready(byte_ready), .byte_last(byte_last_l), .busy(busy_l),
        .word_cnt(word_cnt_l)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          diverge  = 0;
    bit          saw_busy;
    logic [31:0] fifo_q[$];
    logic [7:0]  cap_b[$];
    logic [7:0]  cap_lsb[$];
    logic        cap_l[$];
    int          cap_cyc[$];
    int          rd_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Sample this cycle's outputs, cross the active edge, then update the FIFO model.
    task automatic tick();
        logic rd_now;
        rd_now = fifo_rd;
        if (fifo_rd) rd_cyc.push_back(cyc);
        if (busy) saw_busy = 1'b1;
        if (fifo_rd_l !== fifo_rd || byte_valid_l !== byte_valid ||
            byte_last_l !== byte_last || busy_l !== busy) diverge++;
        if (byte_valid && byte_ready) begin
            cap_b.push_back(byte_out);
            cap_lsb.push_back(byte_out_l);
            cap_l.push_back(byte_last);
            cap_cyc.push_back(cyc);
        end
        @(posedge CLK);
        @(negedge CLK);
        if (rd_now && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr();
        cap_b.delete();
        cap_lsb.delete();
        cap_l.delete();
        cap_cyc.delete();
        rd_cyc.delete();
        saw_busy = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        EN         = 1'b0;
        byte_ready = 1'b1;
        fifo_q.delete();
        fifo_empty = 1'b1;
        ticks(2);
        rst = 1'b0;
        clr();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_fifo_rd"}, fifo_rd, 0);
        check({tag, "_valid"}, byte_valid, 0);
        check({tag, "_last"}, byte_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_byte_out"}, byte_out, 0);
        check({tag, "_word_cnt"}, word_cnt, 0);
    endtask

    // Captured entries base..base+3 must be word w in both byte orders.
    task automatic check_word(input int base, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            if (base + i < cap_b.size()) begin
                check("byte_msb", cap_b[base+i], w[31-8*i -: 8]);
                check("byte_lsb", cap_lsb[base+i], w[8*i +: 8]);
                check("byte_last", cap_l[base+i], (i == 3));
            end else begin
                check("byte_count", cap_b.size(), base + i + 1);
            end
        end
    endtask

    initial begin
        int c0;
        logic [31:0] w;
        rst = 1'b1; EN = 1'b0; byte_ready = 1'b1; fifo_empty = 1'b1; fifo_data = '0;
        @(negedge CLK);

        // Single word, full-rate consumer.
        do_reset();
        check_outputs_zero("reset");
        w = 32'hA1B2C3D4;
        push(w);
        EN = 1'b1;
        c0 = cyc;
        ticks(10);
        check("t1_rd_pulses", rd_cyc.size(), 1);
        if (rd_cyc.size() > 0) check("t1_rd_cycle", rd_cyc[0], c0 + 1);
        check_word(0, w);
        for (int i = 0; i < 4; i++)
            if (i < cap_cyc.size()) check("t1_byte_cycle", cap_cyc[i], c0 + 3 + i);
        check("t1_word_cnt", word_cnt, 1);
        check("t1_word_cnt_lsb", word_cnt_l, 1);
        check("t1_busy_after", busy, 0);

        // Two words back to back.
        do_reset();
        push(32'h01020304);
        push(32'h05060708);
        EN = 1'b1;
        ticks(20);
        check("t2_rd_pulses", rd_cyc.size(), 2);
        if (rd_cyc.size() > 1) check("t2_rd_spacing", rd_cyc[1] - rd_cyc[0], 7);
        check_word(0, 32'h01020304);
        check_word(4, 32'h05060708);
        check("t2_word_cnt", word_cnt, 2);

        // Backpressure while the second byte is presented.
        do_reset();
        w = 32'hA1B2C3D4;
        push(w);
        EN = 1'b1;
        ticks(4);
        byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_byte", byte_out, 8'hB2);
            check("t3_hold_valid", byte_valid, 1);
            check("t3_hold_last", byte_last, 0);
            tick();
        end
        byte_ready = 1'b1;
        ticks(6);
        check("t3_rd_pulses", rd_cyc.size(), 1);
        check("t3_bytes", cap_b.size(), 4);
        check_word(0, w);
        check("t3_word_cnt", word_cnt, 1);

        // Empty FIFO, then EN gating, then EN dropped mid-word.
        do_reset();
        EN = 1'b1;
        ticks(6);
        check("t4_empty_rd", rd_cyc.size(), 0);
        check("t4_empty_busy", saw_busy, 0);
        EN = 1'b0;
        w = 32'hCAFE0D15;
        push(w);
        ticks(6);
        check("t4_en0_rd", rd_cyc.size(), 0);
        check("t4_en0_busy", saw_busy, 0);
        EN = 1'b1;
        c0 = cyc;
        tick();
        EN = 1'b0;
        ticks(9);
        check("t4_rd_pulses", rd_cyc.size(), 1);
        if (rd_cyc.size() > 0) check("t4_rd_cycle", rd_cyc[0], c0 + 1);
        check_word(0, w);
        check("t4_word_cnt", word_cnt, 1);

        // Reset while the second byte of the second word is presented.
        do_reset();
        push(32'hA1B2C3D4);
        push(32'h55667788);
        push(32'h11223344);
        EN = 1'b1;
        ticks(11);
        check("t6_pre_byte", byte_out, 8'h66);
        check("t6_pre_cnt", word_cnt, 1);
        rst = 1'b1;
        tick();
        check_outputs_zero("t6_rst");
        rst = 1'b0;
        clr();
        c0 = cyc;
        ticks(10);
        check("t6_rd_pulses", rd_cyc.size(), 1);
        if (rd_cyc.size() > 0) check("t6_rd_cycle", rd_cyc[0], c0 + 1);
        if (cap_cyc.size() > 0) check("t6_first_byte_cycle", cap_cyc[0], c0 + 3);
        check_word(0, 32'h11223344);
        check("t6_word_cnt", word_cnt, 1);

        // Counter wrap on the 2-bit instance.
        do_reset();
        for (int i = 0; i < 5; i++) push(32'h10203040 + i);
        EN = 1'b1;
        ticks(40);
        check("t7_rd_pulses", rd_cyc.size(), 5);
        check("t7_word_cnt", word_cnt, 5);
        check("t7_word_cnt_wrap", word_cnt_l, 1);
        check_word(16, 32'h10203044);

        check("lsb_ctrl_match", diverge, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
